ring_packet_writer: RTL and testbench

RING_PACKET_WRITER -- requirements
Module: ring_packet_writer

---
 rtl/ring_packet_writer_pkg.sv | 31 +++
 rtl/ring_packet_writer_if.sv | 40 ++++
 rtl/ring_push_timer.sv | 37 +++
 rtl/ring_packet_writer.sv | 208 ++++++++++++++++++++
 tb/tb_ring_packet_writer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_packet_writer_pkg.sv
// Shared types for the ring buffer slice: ring pointer/free-count types,
// the packet writer state encoding and its result codes.
package ring_packet_writer_pkg;

   localparam int RING_FREE_W = 16;

   typedef logic [RING_FREE_W-1:0] ring_free_t;
   typedef logic [15:0]            ring_addr_t;

   typedef struct packed {
      ring_addr_t wr_ptr;
      ring_addr_t rd_ptr;
   } ring_ptrs_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_PUSH,
      ST_WAIT,
      ST_COMMIT,
      ST_ROLLBACK
   } rpw_state_e;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE     = 2'd0;
   localparam err_code_t ERR_OVERFLOW = 2'd1;
   localparam err_code_t ERR_FRAMING  = 2'd2;
   localparam err_code_t ERR_ABORT    = 2'd3;

endpackage

// File: rtl/ring_packet_writer_if.sv
// Bundle of the packet writer's stream, push-port, ring transaction and
// result signals. master = the writer, slave = its environment.
interface ring_packet_writer_if
   import ring_packet_writer_pkg::*;
#(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_first;
   logic              in_last;
   logic              in_ready;
   logic              abort;

   logic              push_request;
   logic [DATA_W-1:0] push_data;
   logic              push_done;

   logic              rc_open;
   logic              rc_commit;
   logic              rc_rollback;
   ring_free_t        rc_free;

   logic              pkt_ok;
   logic              pkt_err;
   err_code_t         err_code;

   modport master (
      input  in_valid, in_data, in_first, in_last, abort, push_done, rc_free,
      output in_ready, push_request, push_data, rc_open, rc_commit, rc_rollback,
             pkt_ok, pkt_err, err_code
   );

   modport slave (
      output in_valid, in_data, in_first, in_last, abort, push_done, rc_free,
      input  in_ready, push_request, push_data, rc_open, rc_commit, rc_rollback,
             pkt_ok, pkt_err, err_code
   );

endinterface

// File: rtl/ring_push_timer.sv
// Elapsed-cycle watchdog for an outstanding push. i_load on the request
// cycle; o_expire rises when TIMEOUT cycles have elapsed at the next edge,
// so a transition taken on o_expire lands exactly TIMEOUT cycles after load.
module ring_push_timer
   import ring_packet_writer_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_clear,
   output logic o_expire
);

   localparam int            TW  = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LIM = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_cnt;
   logic          r_run;

   assign o_expire = r_run && (r_cnt >= LIM);

   // Count cycles since load; saturate at the limit so it cannot wrap.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_run <= 1'b1;
         r_cnt <= TW'(1);
      end else if (r_run && !o_expire) begin
         r_cnt <= r_cnt + TW'(1);
      end
   end

endmodule

// File: rtl/ring_packet_writer.sv
// Packet writer: takes a first/last framed word stream, pushes each word
// into the ring buffer one at a time, and brackets the packet with a ring
// open/commit or open/rollback transaction.
module ring_packet_writer
   import ring_packet_writer_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int MAX_WORDS    = 256,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   ring_packet_writer_if.master bus
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   // Packet budget is whatever the ring can hold, capped at MAX_WORDS.
   function automatic logic [CNT_W-1:0] f_budget(input ring_free_t free);
      if (32'(free) > 32'(MAX_WORDS))
         return CNT_W'(MAX_WORDS);
      else
         return CNT_W'(free);
   endfunction

   rpw_state_e        r_state, w_state_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic              r_last, w_last_nxt;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [CNT_W-1:0]  r_budget, w_budget_nxt;
   err_code_t         r_err, w_err_nxt;
   logic              r_abort, w_abort_nxt;

   logic      w_ready;
   logic      w_xfer;
   logic      w_push_request;
   logic      w_rc_open;
   logic      w_rc_commit;
   logic      w_rc_rollback;
   logic      w_pkt_ok;
   logic      w_pkt_err;
   err_code_t w_err_code;
   logic      w_tmr_load;
   logic      w_tmr_clear;
   logic      w_tmr_expire;

   // No word is taken while reset is held so nothing slips into a packet.
   assign w_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_ACCEPT));
   assign w_xfer  = bus.in_valid && w_ready;

   ring_push_timer #(
      .TIMEOUT (DONE_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_tmr_load),
      .i_clear  (w_tmr_clear),
      .o_expire (w_tmr_expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, datapath next values and all pulse outputs; every output
   // is forced low while reset is held.
   always_comb begin
      w_state_nxt    = r_state;
      w_data_nxt     = r_data;
      w_last_nxt     = r_last;
      w_count_nxt    = r_count;
      w_budget_nxt   = r_budget;
      w_err_nxt      = r_err;
      w_abort_nxt    = r_abort;
      w_push_request = 1'b0;
      w_rc_open      = 1'b0;
      w_rc_commit    = 1'b0;
      w_rc_rollback  = 1'b0;
      w_pkt_ok       = 1'b0;
      w_pkt_err      = 1'b0;
      w_err_code     = ERR_NONE;
      w_tmr_load     = 1'b0;
      w_tmr_clear    = 1'b0;

      if (!rst) begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  if (bus.in_first) begin
                     w_rc_open    = 1'b1;
                     w_budget_nxt = f_budget(bus.rc_free);
                     w_count_nxt  = '0;
                     w_data_nxt   = bus.in_data;
                     w_last_nxt   = bus.in_last;
                     w_err_nxt    = ERR_NONE;
                     w_abort_nxt  = 1'b0;
                     w_state_nxt  = ST_PUSH;
                  end else begin
                     // Orphan word outside a packet: report and drop.
                     w_pkt_err  = 1'b1;
                     w_err_code = ERR_FRAMING;
                  end
               end
            end

            ST_ACCEPT: begin
               if (bus.abort) begin
                  w_err_nxt   = ERR_ABORT;
                  w_state_nxt = ST_ROLLBACK;
               end else if (w_xfer) begin
                  if (bus.in_first) begin
                     w_err_nxt   = ERR_FRAMING;
                     w_state_nxt = ST_ROLLBACK;
                  end else begin
                     w_data_nxt  = bus.in_data;
                     w_last_nxt  = bus.in_last;
                     w_state_nxt = ST_PUSH;
                  end
               end
            end

            ST_PUSH: begin
               // Abort wins so no push is started for a packet being dropped.
               if (bus.abort) begin
                  w_err_nxt   = ERR_ABORT;
                  w_state_nxt = ST_ROLLBACK;
               end else if (r_count == r_budget) begin
                  w_err_nxt   = ERR_OVERFLOW;
                  w_state_nxt = ST_ROLLBACK;
               end else begin
                  w_push_request = 1'b1;
                  w_count_nxt    = r_count + CNT_W'(1);
                  w_tmr_load     = 1'b1;
                  w_state_nxt    = ST_WAIT;
               end
            end

            ST_WAIT: begin
               // An abort here must not cut off the in-flight push; remember it.
               if (bus.abort) w_abort_nxt = 1'b1;
               if (bus.push_done) begin
                  w_tmr_clear = 1'b1;
                  if (r_abort || bus.abort) begin
                     w_err_nxt   = ERR_ABORT;
                     w_state_nxt = ST_ROLLBACK;
                  end else if (r_last) begin
                     w_state_nxt = ST_COMMIT;
                  end else begin
                     w_state_nxt = ST_ACCEPT;
                  end
               end else if (w_tmr_expire) begin
                  w_tmr_clear = 1'b1;
                  w_err_nxt   = ERR_ABORT;
                  w_state_nxt = ST_ROLLBACK;
               end
            end

            ST_COMMIT: begin
               w_rc_commit = 1'b1;
               w_pkt_ok    = 1'b1;
               w_state_nxt = ST_IDLE;
            end

            ST_ROLLBACK: begin
               w_rc_rollback = 1'b1;
               w_pkt_err     = 1'b1;
               w_err_code    = r_err;
               w_abort_nxt   = 1'b0;
               w_state_nxt   = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Packet context: latched word, word count, budget, error and abort latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data   <= '0;
         r_last   <= 1'b0;
         r_count  <= '0;
         r_budget <= '0;
         r_err    <= ERR_NONE;
         r_abort  <= 1'b0;
      end else begin
         r_data   <= w_data_nxt;
         r_last   <= w_last_nxt;
         r_count  <= w_count_nxt;
         r_budget <= w_budget_nxt;
         r_err    <= w_err_nxt;
         r_abort  <= w_abort_nxt;
      end
   end

   assign bus.in_ready     = w_ready;
   assign bus.push_request = w_push_request;
   assign bus.push_data    = r_data;
   assign bus.rc_open      = w_rc_open;
   assign bus.rc_commit    = w_rc_commit;
   assign bus.rc_rollback  = w_rc_rollback;
   assign bus.pkt_ok       = w_pkt_ok;
   assign bus.pkt_err      = w_pkt_err;
   assign bus.err_code     = w_err_code;

endmodule

// File: tb/tb_ring_packet_writer.sv
// Directed bench for ring_packet_writer: framed packets, overflow,
// timeout, framing errors, abort and mid-packet reset.
module tb_ring_packet_writer;
   import ring_packet_writer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ring_packet_writer_if #(.DATA_W(16)) bus ();

   ring_packet_writer #(
      .DATA_W       (16),
      .MAX_WORDS    (256),
      .DONE_TIMEOUT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder, sampled mid-cycle.
   int n_open = 0, n_push = 0, n_commit = 0, n_rb = 0, n_ok = 0, n_err = 0;
   int t_open = 0, t_push = 0, t_commit = 0, t_rb = 0;
   logic [1:0]  last_err = 2'd0;
   logic [15:0] push_log [0:63];

   always @(negedge clk) begin
      if (bus.rc_open)      begin n_open++;   t_open = cyc;   end
      if (bus.push_request) begin push_log[n_push[5:0]] = bus.push_data; n_push++; t_push = cyc; end
      if (bus.rc_commit)    begin n_commit++; t_commit = cyc; end
      if (bus.rc_rollback)  begin n_rb++;     t_rb = cyc;     end
      if (bus.pkt_ok)       n_ok++;
      if (bus.pkt_err)      begin n_err++; last_err = bus.err_code; end
   end

   // push_done responder: done_lat cycles after each request, 0 = never.
   int done_lat = 3;
   initial begin
      bus.push_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.push_request && done_lat > 0) begin
            repeat (done_lat) @(posedge clk);
            #1 bus.push_done = 1'b1;
            @(posedge clk);
            #1 bus.push_done = 1'b0;
         end
      end
   end

   int b_open, b_push, b_commit, b_rb, b_ok, b_err;

   task automatic snap();
      b_open = n_open; b_push = n_push; b_commit = n_commit;
      b_rb = n_rb; b_ok = n_ok; b_err = n_err;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cnt(input int w);
      case (w)
         0: return n_push;
         1: return n_commit;
         default: return n_rb;
      endcase
   endfunction

   // Returns mid-cycle (after the recorder) once the counter reaches target.
   task automatic wait_cnt(input string tag, input int w, input int target, input int bound);
      int i = 0;
      while (cnt(w) < target && i < bound) begin
         @(negedge clk); #1;
         i++;
      end
      chk(tag, 32'(cnt(w) >= target), 32'd1);
   endtask

   task automatic send(input logic [15:0] d, input logic f, input logic l);
      bit done = 1'b0;
      bus.in_data = d; bus.in_first = f; bus.in_last = l; bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
      chk("send_accepted", 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_first = 1'b0;
      bus.in_last = 1'b0; bus.abort = 1'b0; bus.rc_free = 16'd100;
      idle(3);
      rst = 1'b0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_push_req", 32'(bus.push_request), 32'd0);
      chk("rst_push_data", 32'(bus.push_data), 32'd0);
      chk("rst_err_code", 32'(bus.err_code), 32'd0);
      chk("rst_rc_pulses", 32'(n_open + n_commit + n_rb), 32'd0);
      idle(1);

      // Three-word packet, push_done 3 cycles after each request
      snap(); done_lat = 3; bus.rc_free = 16'd100;
      send(16'hABCD, 1'b1, 1'b0);
      send(16'hEF01, 1'b0, 1'b0);
      send(16'h2345, 1'b0, 1'b1);
      wait_cnt("p3_commit_seen", 1, b_commit + 1, 40);
      idle(1);
      chk("p3_opens", 32'(n_open - b_open), 32'd1);
      chk("p3_pushes", 32'(n_push - b_push), 32'd3);
      chk("p3_word0", 32'(push_log[b_push[5:0]]), 32'hABCD);
      chk("p3_word1", 32'(push_log[6'(b_push + 1)]), 32'hEF01);
      chk("p3_word2", 32'(push_log[6'(b_push + 2)]), 32'h2345);
      chk("p3_commits", 32'(n_commit - b_commit), 32'd1);
      chk("p3_ok", 32'(n_ok - b_ok), 32'd1);
      chk("p3_no_err", 32'(n_err - b_err), 32'd0);

      // Single-word packet and minimum turnaround
      snap();
      send(16'h6789, 1'b1, 1'b1);
      wait_cnt("p1_commit_seen", 1, b_commit + 1, 30);
      idle(1);
      chk("p1_pushes", 32'(n_push - b_push), 32'd1);
      chk("p1_word", 32'(push_log[b_push[5:0]]), 32'h6789);
      chk("p1_ok", 32'(n_ok - b_ok), 32'd1);
      chk("p1_turnaround", 32'(t_commit - t_open), 32'd5);

      // Exactly-budget packet commits
      snap(); bus.rc_free = 16'd2;
      send(16'h0A0A, 1'b1, 1'b0);
      send(16'h0B0B, 1'b0, 1'b1);
      wait_cnt("eb_commit_seen", 1, b_commit + 1, 40);
      idle(1);
      chk("eb_pushes", 32'(n_push - b_push), 32'd2);
      chk("eb_no_rb", 32'(n_rb - b_rb), 32'd0);

      // Overflow: budget 2, three words
      snap();
      send(16'h1111, 1'b1, 1'b0);
      send(16'h2222, 1'b0, 1'b0);
      send(16'h3333, 1'b0, 1'b1);
      wait_cnt("ov_rb_seen", 2, b_rb + 1, 30);
      idle(2);
      chk("ov_pushes", 32'(n_push - b_push), 32'd2);
      chk("ov_commits", 32'(n_commit - b_commit), 32'd0);
      chk("ov_err_code", 32'(last_err), 32'd1);
      chk("ov_err_cnt", 32'(n_err - b_err), 32'd1);
      bus.rc_free = 16'd100;

      // Timeout: push_done withheld
      snap(); done_lat = 0;
      send(16'h5A5A, 1'b1, 1'b1);
      wait_cnt("to_rb_seen", 2, b_rb + 1, 30);
      idle(1);
      chk("to_delay", 32'(t_rb - t_push), 32'd8);
      chk("to_err_code", 32'(last_err), 32'd3);
      chk("to_commits", 32'(n_commit - b_commit), 32'd0);
      done_lat = 3;

      // Second in_first mid-packet
      snap();
      send(16'h7001, 1'b1, 1'b0);
      send(16'h7002, 1'b1, 1'b0);
      wait_cnt("fr_rb_seen", 2, b_rb + 1, 30);
      idle(1);
      chk("fr_pushes", 32'(n_push - b_push), 32'd1);
      chk("fr_err_code", 32'(last_err), 32'd2);

      // Orphan word in IDLE
      snap();
      send(16'h4444, 1'b0, 1'b0);
      idle(3);
      chk("orph_err_cnt", 32'(n_err - b_err), 32'd1);
      chk("orph_err_code", 32'(last_err), 32'd2);
      chk("orph_no_open", 32'(n_open - b_open), 32'd0);
      chk("orph_no_rb", 32'(n_rb - b_rb), 32'd0);

      // Abort during WAIT: rollback only after push_done
      snap(); done_lat = 5;
      send(16'h8888, 1'b1, 1'b0);
      wait_cnt("aw_push_seen", 0, b_push + 1, 20);
      idle(1);
      bus.abort = 1'b1;
      idle(1);
      bus.abort = 1'b0;
      idle(1);
      chk("aw_data_held", 32'(bus.push_data), 32'h8888);
      chk("aw_no_early_rb", 32'(n_rb - b_rb), 32'd0);
      wait_cnt("aw_rb_seen", 2, b_rb + 1, 20);
      idle(1);
      chk("aw_delay", 32'(t_rb - t_push), 32'd6);
      chk("aw_err_code", 32'(last_err), 32'd3);
      chk("aw_commits", 32'(n_commit - b_commit), 32'd0);
      done_lat = 3;

      // Abort in ACCEPT
      snap();
      send(16'h9999, 1'b1, 1'b0);
      wait_cnt("aa_push_seen", 0, b_push + 1, 20);
      idle(4);
      bus.abort = 1'b1;
      idle(1);
      bus.abort = 1'b0;
      wait_cnt("aa_rb_seen", 2, b_rb + 1, 20);
      idle(1);
      chk("aa_delay", 32'(t_rb - t_push), 32'd5);
      chk("aa_err_code", 32'(last_err), 32'd3);
      chk("aa_pushes", 32'(n_push - b_push), 32'd1);

      // Reset mid-packet: no rc pulses, outputs cleared
      snap(); done_lat = 0;
      send(16'hC0DE, 1'b1, 1'b1);
      wait_cnt("rm_push_seen", 0, b_push + 1, 20);
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rm_push_data", 32'(bus.push_data), 32'd0);
      chk("rm_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rm_err_code", 32'(bus.err_code), 32'd0);
      idle(12);
      chk("rm_no_rb", 32'(n_rb - b_rb), 32'd0);
      chk("rm_no_commit", 32'(n_commit - b_commit), 32'd0);
      chk("rm_no_err", 32'(n_err - b_err), 32'd0);

      // Recovery after reset
      snap(); done_lat = 3;
      send(16'h6789, 1'b1, 1'b1);
      wait_cnt("rc_commit_seen", 1, b_commit + 1, 30);
      idle(1);
      chk("rc_ok", 32'(n_ok - b_ok), 32'd1);
      chk("rc_word", 32'(push_log[b_push[5:0]]), 32'h6789);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
